lu_arbiter: RTL

LU_ARBITER -- requirements
Module: lu_arbiter

---
 rtl/lu_pkg.sv | 20 ++
 rtl/lu_core.sv | 22 ++
 rtl/lu_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the lu_arbiter slice: sizes, op encodings and FSM states.
package lu_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned CNT_W   = 8;

    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR = 2'b10;
    localparam logic [OP_W-1:0] OP_NOT = 2'b11;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

endpackage

// File: rtl/lu_core.sv
// Shared combinational 4-bit logic unit: AND / OR / XOR / NOT x.
module lu_core
    import lu_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] f
);

    always_comb begin
        f = '0;
        unique case (op)
            OP_AND:  f = x & y;
            OP_OR:   f = x | y;
            OP_XOR:  f = x ^ y;
            OP_NOT:  f = ~x;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter sharing one lu_core among four requesters.
// Optional saturating per-requester grant counters when LU_ARBITER_STATS_EN is defined.
module lu_arbiter
    import lu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    input  logic [NUM_REQ*DATA_W-1:0] req_y,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_f,
`ifdef LU_ARBITER_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt,
`endif
    input  logic                      resp_ready
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] f_q;

    logic              grant_any;
    logic              grant;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   cand;
    logic [DATA_W-1:0] core_x, core_y, core_f;
    logic [OP_W-1:0]   core_op;

    // Search starts one past the last grant and wraps; offset NUM_REQ lands back on ptr_q.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = ptr_q;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr_q + ID_W'(i);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign grant = (state_q == StIdle) && !rst && grant_any;

    assign core_x  = req_x[grant_id*DATA_W +: DATA_W];
    assign core_y  = req_y[grant_id*DATA_W +: DATA_W];
    assign core_op = req_op[grant_id*OP_W +: OP_W];

    lu_core u_core (
        .x  (core_x),
        .y  (core_y),
        .op (core_op),
        .f  (core_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StHold;
            StHold:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[grant_id] = 1'b1;
        resp_valid = (state_q == StHold);
        resp_f     = resp_valid ? f_q  : '0;
        resp_id    = resp_valid ? id_q : '0;
    end

    // Pointer resets to the last index so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
            id_q  <= '0;
            f_q   <= '0;
        end else if (grant) begin
            ptr_q <= grant_id;
            id_q  <= grant_id;
            f_q   <= core_f;
        end
    end

`ifdef LU_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (grant && (cnt_q[grant_id] != '1)) begin
            cnt_q[grant_id] <= cnt_q[grant_id] + 1'b1;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule
